// File: rtl/jpeg_cone_eval_scheduler.sv
// Purpose : round-robin shares one combinational timing cone between two requesters;
//           drives a registered vector into the cone, waits SETTLE cycles, returns the sampled bit.
// Latency : accept at edge T -> cone_out sampled and rsp_valid high at edge T+SETTLE.
// Backpressure: rsp_ready low holds the response in RESP indefinitely; req_ready stays 0 meanwhile.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[1:0]          per-requester request valid
//   req_ready[1:0]          per-requester accept (one-hot or zero, only in IDLE)
//   req_vec0/1, req_tag0/1  per-requester cone input vector and tag
//   cone_in / cone_out      registered drive into the cone / cone result
//   rsp_valid/ready         response handshake; rsp_data, rsp_tag, rsp_src payload
//   busy                    high whenever not IDLE
//   done_cnt                completed responses, wraps modulo 2^CNT_W
module jpeg_cone_eval_scheduler #(
   parameter int IN_W   = 25,
   parameter int TAG_W  = 4,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [IN_W-1:0]  req_vec0,
   input  logic [IN_W-1:0]  req_vec1,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   output logic [IN_W-1:0]  cone_in,
   input  logic             cone_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_src,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   // SETTLE is at most 15, so a 4-bit down-counter covers the whole range.
   localparam int SCW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic [SCW-1:0]   cnt;
   logic [1:0]       grant;
   logic             accept;
   logic             acc_idx;

   // Grant: a lone requester wins; on contention the priority pointer decides.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready = (state == S_IDLE) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign acc_idx   = req_ready[1];
   assign busy      = (state != S_IDLE);

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept)                 state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == '0)              state_nxt = S_RESP;
         S_RESP:   if (rsp_ready)              state_nxt = S_IDLE;
         default:                              state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath. cone_in is loaded only on accept so the cone input never glitches
   // while a result is settling or being held for the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= 1'b0;
         cnt       <= '0;
         cone_in   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_tag   <= '0;
         rsp_src   <= 1'b0;
         done_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cone_in <= acc_idx ? req_vec1 : req_vec0;
                  rsp_tag <= acc_idx ? req_tag1 : req_tag0;
                  rsp_src <= acc_idx;
                  cnt     <= SCW'(SETTLE - 1);
                  ptr     <= ~acc_idx;
               end
            end
            S_SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - SCW'(1);
               end else begin
                  rsp_data  <= cone_out;
                  rsp_valid <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  done_cnt  <= done_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_cone_eval_scheduler.sv
// Bench for jpeg_cone_eval_scheduler: directed table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
// The cone is modelled as the XOR-reduction of cone_in.
module tb_jpeg_cone_eval_scheduler;

   localparam int IN_W   = 25;
   localparam int TAG_W  = 4;
   localparam int SETTLE = 2;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [IN_W-1:0]  req_vec0, req_vec1;
   logic [TAG_W-1:0] req_tag0, req_tag1;
   logic [IN_W-1:0]  cone_in;
   logic             cone_out;
   logic             rsp_valid, rsp_ready, rsp_data, rsp_src, busy;
   logic [TAG_W-1:0] rsp_tag;
   logic [15:0]      done_cnt;

   // second instance with a narrow counter, same stimulus, for the wrap check
   logic [1:0]       req_ready_w;
   logic [IN_W-1:0]  cone_in_w;
   logic             cone_out_w, rsp_valid_w, rsp_data_w, rsp_src_w, busy_w;
   logic [TAG_W-1:0] rsp_tag_w;
   logic [3:0]       done_cnt_w;

   assign cone_out   = ^cone_in;
   assign cone_out_w = ^cone_in_w;

   jpeg_cone_eval_scheduler #(.IN_W(IN_W), .TAG_W(TAG_W), .SETTLE(SETTLE), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_vec0(req_vec0), .req_vec1(req_vec1), .req_tag0(req_tag0), .req_tag1(req_tag1),
      .cone_in(cone_in), .cone_out(cone_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_src(rsp_src), .busy(busy), .done_cnt(done_cnt)
   );

   jpeg_cone_eval_scheduler #(.IN_W(IN_W), .TAG_W(TAG_W), .SETTLE(SETTLE), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
      .req_vec0(req_vec0), .req_vec1(req_vec1), .req_tag0(req_tag0), .req_tag1(req_tag1),
      .cone_in(cone_in_w), .cone_out(cone_out_w), .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_w), .rsp_tag(rsp_tag_w), .rsp_src(rsp_src_w), .busy(busy_w),
      .done_cnt(done_cnt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // transaction-level reference model
   bit               m_inflight;
   int               m_t_cap;     // cycle index at which the response becomes visible
   logic [IN_W-1:0]  m_vec;
   logic [TAG_W-1:0] m_tag;
   logic             m_src;
   logic             m_ptr;
   logic [IN_W-1:0]  m_cone_in;
   int               m_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_inflight = 0;
      m_t_cap    = 0;
      m_vec      = '0;
      m_tag      = '0;
      m_src      = 1'b0;
      m_ptr      = 1'b0;
      m_cone_in  = '0;
      m_done     = 0;
   endtask

   task automatic apply(input logic [1:0] rv, input logic rr);
      req_valid = rv;
      rsp_ready = rr;
      #1;
   endtask

   // Compare all outputs with the model, then advance the model across the coming edge.
   task automatic model_check();
      logic [1:0] g;
      logic       exp_rv;
      logic       idx;
      g = 2'b00;
      if (!m_inflight) begin
         if (req_valid == 2'b01)      g = 2'b01;
         else if (req_valid == 2'b10) g = 2'b10;
         else if (req_valid == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
      end
      exp_rv = m_inflight && (cyc >= m_t_cap);
      chk("req_ready", 64'(req_ready), 64'(g));
      chk("busy", 64'(busy), 64'(m_inflight));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("cone_in", 64'(cone_in), 64'(m_cone_in));
      chk("done_cnt", 64'(done_cnt), 64'(m_done % 65536));
      chk("done_cnt_w", 64'(done_cnt_w), 64'(m_done % 16));
      if (exp_rv) begin
         chk("rsp_data", 64'(rsp_data), 64'(^m_vec));
         chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
         chk("rsp_src", 64'(rsp_src), 64'(m_src));
      end
      if (g != 2'b00) begin
         idx        = g[1];
         m_inflight = 1;
         m_vec      = idx ? req_vec1 : req_vec0;
         m_tag      = idx ? req_tag1 : req_tag0;
         m_src      = idx;
         m_cone_in  = m_vec;
         m_ptr      = ~idx;
         m_t_cap    = cyc + 1 + SETTLE;
      end else if (exp_rv && rsp_ready) begin
         m_inflight = 0;
         m_done++;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic step(input logic [1:0] rv, input logic rr);
      apply(rv, rr);
      model_check();
      advance();
   endtask

   // Called at a negedge; asserts reset, checks reset values, releases at the next negedge.
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_cone_in", 64'(cone_in), 64'd0);
      chk("rst_done_cnt", 64'(done_cnt), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      chk("rst_rsp_src", 64'(rsp_src), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       rst_first;
      logic [1:0] rv;
      logic       rr;
      logic [1:0] rdy;
      logic       busy;
      logic       rvld;
      logic       src;
      int         done;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic             d0;
      logic [TAG_W-1:0] t0;
      logic             s0;
      int               k;

      // single request: accept at edge 0, response at edge 2, complete at edge 3
      tbl[0]  = '{1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0};
      tbl[3]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 0};
      tbl[4]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1};
      // contention: grants 0,1,0 with accepts four cycles apart
      tbl[5]  = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0};
      tbl[6]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0};
      tbl[7]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0};
      tbl[8]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 0};
      tbl[9]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1};
      tbl[11] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1};
      tbl[12] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1};
      tbl[13] = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      req_vec0  = 25'h1ABCDEF;
      req_vec1  = 25'h0F0F0F0;
      req_tag0  = 4'd3;
      req_tag1  = 4'd9;
      model_reset();
      @(negedge clk);

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].rst_first) do_reset();
         apply(tbl[i].rv, tbl[i].rr);
         chk($sformatf("tbl%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
         chk($sformatf("tbl%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rvld));
         chk($sformatf("tbl%0d_done_cnt", i), 64'(done_cnt), 64'(tbl[i].done));
         if (tbl[i].rvld) chk($sformatf("tbl%0d_rsp_src", i), 64'(rsp_src), 64'(tbl[i].src));
         if (i == 1) chk("tbl1_cone_in", 64'(cone_in), 64'(25'h1ABCDEF));
         if (i == 3) begin
            chk("tbl3_rsp_data", 64'(rsp_data), 64'd0);
            chk("tbl3_rsp_tag", 64'(rsp_tag), 64'd3);
         end
         model_check();
         advance();
      end

      // ---- backpressure: hold RESP for 10 cycles ----
      do_reset();
      req_vec0 = 25'h0000007;
      req_tag0 = 4'd11;
      step(2'b01, 1'b0);
      k = 0;
      while (!rsp_valid && k < 20) begin
         step(2'b00, 1'b0);
         k++;
      end
      if (!rsp_valid) chk("bp_rsp_valid_timeout", 64'd0, 64'd1);
      d0 = rsp_data;
      t0 = rsp_tag;
      s0 = rsp_src;
      chk("bp_rsp_data_value", 64'(d0), 64'd1);
      for (int i = 0; i < 10; i++) begin
         apply(2'($urandom_range(1, 3)), 1'b0);
         chk("bp_req_ready_zero", 64'(req_ready), 64'd0);
         chk("bp_rsp_data_stable", 64'(rsp_data), 64'(d0));
         chk("bp_rsp_tag_stable", 64'(rsp_tag), 64'(t0));
         chk("bp_rsp_src_stable", 64'(rsp_src), 64'(s0));
         model_check();
         advance();
      end
      step(2'b00, 1'b1);
      apply(2'b00, 1'b0);
      chk("bp_single_completion", 64'(done_cnt), 64'd1);
      model_check();
      advance();
      step(2'b00, 1'b1);

      // ---- mid-transaction reset: accept req0 (ptr -> 1), reset in SETTLE ----
      do_reset();
      req_vec0 = 25'h155AA33;
      req_tag0 = 4'd5;
      step(2'b01, 1'b1);
      apply(2'b00, 1'b1);
      chk("mid_busy_before_reset", 64'(busy), 64'd1);
      model_check();
      do_reset();
      apply(2'b11, 1'b1);
      chk("mid_ptr_cleared", 64'(req_ready), 64'b01);
      model_check();
      advance();
      for (int i = 0; i < 6; i++) step(2'b00, 1'b1);

      // ---- counter wrap: 17 completions on the 4-bit instance ----
      do_reset();
      k = 0;
      while (m_done < 17 && k < 200) begin
         req_vec0 = IN_W'($urandom);
         req_vec1 = IN_W'($urandom);
         req_tag0 = TAG_W'($urandom);
         req_tag1 = TAG_W'($urandom);
         step(2'($urandom_range(1, 3)), 1'b1);
         k++;
      end
      apply(2'b00, 1'b1);
      chk("wrap_done_cnt_w", 64'(done_cnt_w), 64'd1);
      chk("wrap_done_cnt", 64'(done_cnt), 64'd17);
      model_check();
      advance();
      for (int i = 0; i < 3; i++) begin
         req_vec0 = IN_W'($urandom);
         step(2'b00, 1'b1);
      end

      // ---- randomized traffic ----
      for (int i = 0; i < 600; i++) begin
         req_vec0 = IN_W'($urandom);
         req_vec1 = IN_W'($urandom);
         req_tag0 = TAG_W'($urandom);
         req_tag1 = TAG_W'($urandom);
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jpeg_cone_eval_scheduler.md
# jpeg_cone_eval_scheduler

Sequencer and arbiter for the JPEG timing-cone datapath. The cone is a 25-input, 1-output combinational block. This block shares the cone between two requesters using round-robin arbitration. For each granted request it drives a registered input vector into the cone, waits a programmable settle time, captures the cone output and returns it with the requester's tag over a valid/ready response channel.

## Interface
Parameters:
- IN_W, 25, width of the cone input vector
- TAG_W, 4, width of the transaction tag
- SETTLE, 2, cycles from cone_in update to capture; legal range 1..15
- CNT_W, 16, width of the completed-transaction counter

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_vec0  in  IN_W  requester 0 input vector
- req_vec1  in  IN_W  requester 1 input vector
- req_tag0  in  TAG_W  requester 0 tag
- req_tag1  in  TAG_W  requester 1 tag
- cone_in  out  IN_W  registered drive into the cone
- cone_out  in  1  cone result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  1  captured cone_out
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_src  out  1  index of the served requester
- busy  out  1  high whenever the state is not IDLE
- done_cnt  out  CNT_W  count of completed responses

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: the grant is computed combinationally from req_valid and the priority pointer ptr.
  - If only one requester is valid, it is granted.
  - If both are valid, requester ptr is granted.
  - req_ready = grant when the state is IDLE, else 0.
  - req_ready may depend combinationally on req_valid.
- On an accept edge (req_valid[i] & req_ready[i]):
  - cone_in <= req_veci; rsp_tag <= req_tagi; rsp_src <= i.
  - cnt <= SETTLE-1; ptr <= ~i; state <= SETTLE.
- SETTLE:
  - cnt != 0: decrement cnt each edge.
  - cnt == 0: rsp_data <= cone_out; rsp_valid <= 1; state <= RESP.
- RESP: hold rsp_valid, rsp_data, rsp_tag and rsp_src stable until rsp_valid & rsp_ready. On that edge: rsp_valid <= 0, done_cnt <= done_cnt+1 (wraps modulo 2^CNT_W), state <= IDLE.
- cone_in keeps its last value outside SETTLE. It changes only on accept edges, so the cone sees no glitches.
- req_valid changes during SETTLE or RESP are ignored; no request is accepted outside IDLE.
- ptr changes only on accept edges.

## Timing
- Reset values: state IDLE, ptr 0, cone_in 0, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_src 0, cnt 0, done_cnt 0. Derived outputs at reset: busy 0, req_ready 0 (since req_valid is 0).
- Reset assertion mid-transaction clears the state immediately. The in-flight transaction is dropped with no response. done_cnt is not incremented.
- Latency: with accept at edge T, cone_out is sampled at edge T+SETTLE and rsp_valid is high from T+SETTLE.
- Throughput: with rsp_ready held high, the response completes at T+SETTLE+1 and the next accept can occur at T+SETTLE+2. One transaction per SETTLE+2 cycles.
- Backpressure: with rsp_ready low, RESP is held indefinitely and req_ready stays 0.
- Simultaneous requests: strict alternation while both requesters stay valid.

## Test plan
- Single request: req_valid=01, vec0=25'h1ABCDEF, tag0=3, SETTLE=2, cone_out modelled as XOR-reduction of cone_in. Required: accept at edge 0; cone_in=25'h1ABCDEF after edge 0; rsp_valid at edge 2; rsp_data=parity of the vector, rsp_tag=3, rsp_src=0; done_cnt=1 after the rsp handshake.
- Contention: both requesters valid continuously, rsp_ready=1. Required grant order 0,1,0,1 with rsp_src matching; accepts spaced 4 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises. Required: rsp_data, rsp_tag and rsp_src stable; req_ready=0 throughout; single completion when rsp_ready rises.
- Mid-transaction reset: assert rst_n=0 during SETTLE. Required: immediately rsp_valid=0, busy=0, cone_in=0, ptr=0; done_cnt unchanged at 0.
- Counter wrap with CNT_W=4: run 17 transactions. Required: done_cnt=1; cone_in holds the last accepted vector between transactions.
